// File: rtl/seq_div.sv
// Restoring divider, one quotient bit per clock: 2M/M -> M quotient + M remainder, done after edge k+M (early exit after edge k).
// No backpressure: start is taken only while idle, and results are held until the next done pulse.
module seq_div #(
  parameter int M = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*M-1:0] A,
  input  logic [M-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [M-1:0]   R,
  output logic [M-1:0]   Res,
  output logic           C,
  output logic           N,
  output logic           V,
  output logic           Z
);

  localparam int CW = $clog2(M);

  typedef enum logic {IDLE, CALC} state_t;

  state_t         state_q;
  logic [M-1:0]   a_lo_q, b_q, q_q;
  logic [M:0]     p_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q, done_q;
  logic [M-1:0]   r_q, res_q;
  logic           c_q, n_q, v_q, z_q;

  logic [M:0]     p_shift_d, p_d;
  logic [M-1:0]   q_d;
  logic           ge_d;

  // Compare on the full M+1 bits: the shifted remainder can reach 2B-1.
  always_comb begin
    p_shift_d   = {p_q[M-1:0], a_lo_q[cnt_q]};
    ge_d        = (p_shift_d >= {1'b0, b_q});
    p_d         = ge_d ? (p_shift_d - {1'b0, b_q}) : p_shift_d;
    q_d         = q_q;
    q_d[cnt_q]  = ge_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_lo_q  <= '0;
      b_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_lo_q <= A[M-1:0];
            b_q    <= B;
            // A zero divisor or an upper half >= B means the quotient cannot fit.
            if (B == '0 || A[2*M-1:M] >= B) begin
              done_q <= 1'b1;
              r_q    <= '1;
              res_q  <= '0;
              c_q    <= (B == '0);
              v_q    <= 1'b1;
              n_q    <= 1'b1;
              z_q    <= 1'b0;
            end else begin
              p_q     <= {1'b0, A[2*M-1:M]};
              q_q     <= '0;
              cnt_q   <= CW'(M - 1);
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          p_q   <= p_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            r_q     <= q_d;
            res_q   <= p_d[M-1:0];
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= q_d[M-1];
            z_q     <= (q_d == '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign R    = r_q;
  assign Res  = res_q;
  assign C    = c_q;
  assign N    = n_q;
  assign V    = v_q;
  assign Z    = z_q;

endmodule
